// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters,
// with an optional locked burst of up to MAX_BURST beats per requester.
module sram_port_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0] req_bmask,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      sram_men,
  output logic                      sram_wen,
  output logic                      sram_ren,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_din,
  output logic [DATA_W-1:0]         sram_bm,
  input  logic [DATA_W-1:0]         sram_dout
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   lock_id_q, lock_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d, beat_inc;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [PTR_W-1:0]   gnt_id;
  logic               gnt_vld, accept;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [DATA_W-1:0]  bmask_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    assign bmask_arr[i] = req_bmask[i*DATA_W +: DATA_W];
  end

  function automatic logic [PTR_W-1:0] next_id(input logic [PTR_W-1:0] id);
    return (id == PTR_W'(NUM_REQ - 1)) ? '0 : id + PTR_W'(1);
  endfunction

  // Rotating scan starting at rr_ptr; index folded manually so non-power-of-two NUM_REQ wraps.
  always_comb begin
    int unsigned      sum;
    logic [PTR_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = 0;
    idx     = '0;
    if (state_q == LOCKED) begin
      gnt_vld = req_valid[lock_id_q];
      gnt_id  = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum = 32'(rr_ptr_q) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        idx = PTR_W'(sum);
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  assign accept = gnt_vld & rst_n;

  always_comb begin
    req_ready = '0;
    sram_men  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    sram_bm   = '0;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
      sram_men  = 1'b1;
      sram_wen  = req_we[gnt_id];
      sram_ren  = ~req_we[gnt_id];
      sram_addr = addr_arr[gnt_id];
      sram_din  = wdata_arr[gnt_id];
      sram_bm   = bmask_arr[gnt_id];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_valid_d = '0;
    beat_inc    = beat_cnt_q + CNT_W'(1);
    if (accept && !req_we[gnt_id]) rsp_valid_d[gnt_id] = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_last[gnt_id]) begin
            rr_ptr_d = next_id(gnt_id);
          end else begin
            state_d    = LOCKED;
            lock_id_d  = gnt_id;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          beat_cnt_d = beat_inc;
          if (req_last[gnt_id] || beat_inc == CNT_W'(MAX_BURST)) begin
            state_d    = IDLE;
            rr_ptr_d   = next_id(lock_id_q);
            beat_cnt_d = '0;
          end
        end else begin
          state_d    = IDLE;
          rr_ptr_d   = next_id(lock_id_q);
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = sram_dout;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus random traffic
// against a transaction-level arbitration and memory model.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int SW = 3 + AW + 2*DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, req_bmask;
  logic [DW-1:0]   rsp_rdata, sram_din, sram_bm, sram_dout;
  logic            sram_men, sram_wen, sram_ren;
  logic [AW-1:0]   sram_addr;

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  // SRAM macro: one-cycle read latency, bit-masked write, untouched words read their seed.
  logic [DW-1:0] mac_mem [1024];
  bit            mac_wr  [1024];
  logic [DW-1:0] mac_dout;
  always @(posedge clk) begin
    if (sram_men) begin
      if (sram_wen)
        mac_mem[sram_addr] <= ((mac_wr[sram_addr] ? mac_mem[sram_addr] : init_word(int'(sram_addr))) & ~sram_bm)
                              | (sram_din & sram_bm);
      if (sram_wen) mac_wr[sram_addr] <= 1'b1;
      if (sram_ren) mac_dout <= mac_wr[sram_addr] ? mac_mem[sram_addr] : init_word(int'(sram_addr));
    end
  end
  assign sram_dout = mac_dout;

  int checks = 0;
  int errors = 0;

  // Requester-side stimulus state.
  logic          v [N], we [N], lst [N];
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N], bmk [N];

  // Reference model: expected memory contents and arbitration bookkeeping.
  logic [DW-1:0] ref_mem [1024];
  int m_ptr, m_owner, m_beats;

  logic [N-1:0]  obs_ready, exp_ready, obs_rsp, exp_rsp;
  logic [SW-1:0] obs_sram, exp_sram;
  logic [DW-1:0] obs_rdata, exp_rdata;
  int            obs_gid, exp_gid;

  function automatic int model_grant();
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_beats = 0;
  endtask

  task automatic model_update(input int g);
    if (m_owner < 0) begin
      if (g >= 0) begin
        if (lst[g]) m_ptr = (g + 1) % N;
        else begin m_owner = g; m_beats = 1; end
      end
    end else if (g >= 0) begin
      m_beats++;
      if (lst[g] || m_beats == MB) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
    end else begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i]; req_we[i] = we[i]; req_last[i] = lst[i];
      req_addr[i*AW +: AW] = ad[i]; req_wdata[i*DW +: DW] = wd[i]; req_bmask[i*DW +: DW] = bmk[i];
    end
  endtask

  task automatic new_req(input int i, input logic wr, input logic last, input logic [AW-1:0] a);
    v[i] = 1'b1; we[i] = wr; lst[i] = last; ad[i] = a;
    wd[i] = $urandom; bmk[i] = $urandom;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; we[i] = 1'b0; lst[i] = 1'b1; ad[i] = '0; wd[i] = '0; bmk[i] = '0;
    end
  endtask

  // One clock: capture combinational outputs before the edge and responses after it,
  // alongside the model's expectations. Called at posedge+1.
  task automatic step();
    int g;
    drive_inputs();
    #2;
    obs_ready = req_ready;
    obs_sram  = {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm};
    obs_gid   = -1;
    for (int i = 0; i < N; i++) if (obs_ready[i]) obs_gid = (obs_gid == -1) ? i : -2;
    g = model_grant();
    exp_gid   = g;
    exp_ready = '0;
    exp_sram  = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_sram = {1'b1, we[g], ~we[g], ad[g], wd[g], bmk[g]};
    end
    @(posedge clk);
    #1;
    obs_rsp   = rsp_valid;
    obs_rdata = rsp_rdata;
    exp_rsp   = '0;
    if (g >= 0 && !we[g]) begin exp_rsp[g] = 1'b1; exp_rdata = ref_mem[ad[g]]; end
    if (g >= 0 && we[g]) ref_mem[ad[g]] = (ref_mem[ad[g]] & ~bmk[g]) | (wd[g] & bmk[g]);
    model_update(g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    drive_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) new_req(i, 1'b0, 1'b1, AW'($urandom));
    drive_inputs();
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
      checks++;
      if ({sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm} !== '0) begin
        errors++; $display("FAIL reset_sram: men=%b wen=%b ren=%b addr=%h expected all zero", sram_men, sram_wen, sram_ren, sram_addr);
      end
      checks++;
      if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp: got %b expected 000", rsp_valid); end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    clear_reqs();
  endtask

  task automatic test_single_read();
    new_req(1, 1'b0, 1'b1, 10'h155);
    step();
    checks++;
    if (obs_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", obs_ready); end
    checks++;
    if (obs_sram !== exp_sram || obs_sram[SW-1] !== 1'b1 || obs_sram[SW-3] !== 1'b1 || obs_sram[2*DW +: AW] !== 10'h155) begin
      errors++; $display("FAIL single_sram: got %h expected %h", obs_sram, exp_sram);
    end
    checks++;
    if (obs_rsp !== 3'b010) begin errors++; $display("FAIL single_rsp: got %b expected 010", obs_rsp); end
    checks++;
    if (obs_rdata !== init_word(10'h155)) begin errors++; $display("FAIL single_rdata: got %h expected %h", obs_rdata, init_word(10'h155)); end
    v[1] = 1'b0;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] prior;
    prior = ref_mem[10'h3FF];
    new_req(0, 1'b1, 1'b1, 10'h3FF);
    wd[0] = 32'hDEADBEEF; bmk[0] = 32'hFFFF0000;
    step();
    checks++;
    if (obs_ready !== 3'b001 || obs_sram !== exp_sram) begin
      errors++; $display("FAIL wr_accept: ready %b sram %h expected 001 / %h", obs_ready, obs_sram, exp_sram);
    end
    checks++;
    if (obs_rsp !== 3'b000) begin errors++; $display("FAIL wr_no_rsp: got %b expected 000", obs_rsp); end
    we[0] = 1'b0;
    step();
    checks++;
    if (obs_rsp !== 3'b001) begin errors++; $display("FAIL rd_rsp: got %b expected 001", obs_rsp); end
    checks++;
    if (obs_rdata !== {16'hDEAD, prior[15:0]}) begin
      errors++; $display("FAIL rd_after_wr: got %h expected %h", obs_rdata, {16'hDEAD, prior[15:0]});
    end
    v[0] = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < N; i++) new_req(i, 1'b0, 1'b1, AW'($urandom));
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (obs_gid !== order[c]) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", c, obs_gid, order[c]); end
      checks++;
      if (obs_rsp !== 3'(1 << order[c]) || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rr_rsp[%0d]: got %b/%h expected %b/%h", c, obs_rsp, obs_rdata, 3'(1 << order[c]), exp_rdata);
      end
      if (exp_gid >= 0) new_req(exp_gid, 1'b0, 1'b1, AW'($urandom));
    end
    clear_reqs();
  endtask

  task automatic test_burst_lock();
    int order [6] = '{2, 2, 2, 2, 0, 1};
    int b2 = 0;
    do_reset();
    new_req(1, 1'b1, 1'b1, AW'($urandom));
    step();
    v[1] = 1'b0;
    new_req(0, 1'b0, 1'b1, AW'($urandom));
    new_req(1, 1'b1, 1'b1, AW'($urandom));
    new_req(2, 1'b1, 1'b0, AW'($urandom));
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (obs_gid !== order[c] || obs_sram !== exp_sram) begin
        errors++; $display("FAIL burst_grant[%0d]: got %0d expected %0d", c, obs_gid, order[c]);
      end
      if (exp_gid == 2) begin
        b2++;
        if (b2 == 4) v[2] = 1'b0;
        else new_req(2, $urandom_range(0, 1), (b2 == 3), AW'($urandom));
      end else if (exp_gid >= 0) v[exp_gid] = 1'b0;
    end
    clear_reqs();
  endtask

  task automatic test_max_burst();
    int order [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    do_reset();
    new_req(0, 1'b0, 1'b0, AW'($urandom));
    new_req(1, 1'b0, 1'b1, AW'($urandom));
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (obs_gid !== order[c]) begin errors++; $display("FAIL maxburst_grant[%0d]: got %0d expected %0d", c, obs_gid, order[c]); end
      checks++;
      if (obs_rsp !== exp_rsp || (exp_rsp != '0 && obs_rdata !== exp_rdata)) begin
        errors++; $display("FAIL maxburst_rsp[%0d]: got %b/%h expected %b/%h", c, obs_rsp, obs_rdata, exp_rsp, exp_rdata);
      end
      if (exp_gid == 0) new_req(0, $urandom_range(0, 1), 1'b0, AW'($urandom));
      else if (exp_gid == 1) v[1] = 1'b0;
    end
    clear_reqs();
  endtask

  task automatic test_abandon();
    int order [4] = '{0, 0, -1, 1};
    do_reset();
    new_req(0, 1'b0, 1'b0, AW'($urandom));
    new_req(1, 1'b0, 1'b1, AW'($urandom));
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (obs_gid !== order[c]) begin errors++; $display("FAIL abandon_grant[%0d]: got %0d expected %0d", c, obs_gid, order[c]); end
      if (c == 1) v[0] = 1'b0;
      else if (exp_gid == 0) new_req(0, 1'b0, 1'b0, AW'($urandom));
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    new_req(1, 1'b0, 1'b1, AW'($urandom));
    drive_inputs();
    #2;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL midrst_accept: got %b expected 010", req_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rsp_valid !== '0 || req_ready !== '0) begin
        errors++; $display("FAIL midrst_hold[%0d]: rsp %b ready %b expected 000/000", c, rsp_valid, req_ready);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    clear_reqs();
    step();
    checks++;
    if (obs_rsp !== '0 || obs_ready !== '0) begin errors++; $display("FAIL midrst_no_rsp: rsp %b ready %b expected 000/000", obs_rsp, obs_ready); end
    for (int i = 0; i < N; i++) new_req(i, 1'b1, 1'b1, AW'($urandom));
    step();
    checks++;
    if (obs_gid !== 0) begin errors++; $display("FAIL midrst_ptr: got grant %0d expected 0", obs_gid); end
    clear_reqs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 2) == 0)
          new_req(i, $urandom_range(0, 1), $urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)));
      step();
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, obs_ready, exp_ready); end
      checks++;
      if (obs_sram !== exp_sram) begin errors++; $display("FAIL rand_sram[%0d]: got %h expected %h", c, obs_sram, exp_sram); end
      checks++;
      if (obs_rsp !== exp_rsp) begin errors++; $display("FAIL rand_rsp[%0d]: got %b expected %b", c, obs_rsp, exp_rsp); end
      if (exp_rsp != '0) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c, obs_rdata, exp_rdata); end
      end
      if (exp_gid >= 0) begin
        if ($urandom_range(0, 1) == 0) v[exp_gid] = 1'b0;
        else new_req(exp_gid, $urandom_range(0, 1), $urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)));
      end
    end
    clear_reqs();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(a);
    clear_reqs();
    drive_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_burst_lock();
    test_max_burst();
    test_abandon();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
